// File: rtl/bsram_subword_pkg.sv
// Shared definitions for the BSRAM sub-word access controller: request size
// encodings, lane widths and the controller state type.
package bsram_subword_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int HALF_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  // req_size encodings; 2'b11 is treated the same as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // True for a full-word request (covers the 2'b11 alias).
  function automatic logic isWordSize(input logic [1:0] size);
    return size >= SIZE_WORD;
  endfunction

endpackage

// File: rtl/subword_lane_mux.sv
// Combinational lane logic for the sub-word controller.
// Store side merges new byte/half data into the old word at the addressed
// lane. Load side extracts the addressed lane and sign- or zero-extends it.
// Lanes are little-endian: byte n lives in bits 8n+7:8n.
module subword_lane_mux
  import bsram_subword_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] word,
  input  logic [WORD_WIDTH-1:0] newData,
  input  logic [1:0]            size,
  input  logic [1:0]            offset,
  input  logic                  isUnsigned,
  output logic [WORD_WIDTH-1:0] mergedWord,
  output logic [WORD_WIDTH-1:0] loadData
);

  logic [BYTE_WIDTH-1:0] byteLane;
  logic [HALF_WIDTH-1:0] halfLane;
  logic                  byteSign;
  logic                  halfSign;

  // Store merge: overwrite only the addressed lane(s) of the old word.
  always_comb begin
    // NOTE: default assignment first so every path drives mergedWord; a
    // missing branch would otherwise infer a latch.
    mergedWord = word;
    case (size)
      SIZE_BYTE: mergedWord[{offset, 3'b000} +: BYTE_WIDTH]      = newData[BYTE_WIDTH-1:0];
      SIZE_HALF: mergedWord[{offset[1], 4'b0000} +: HALF_WIDTH] = newData[HALF_WIDTH-1:0];
      default:   mergedWord = newData;
    endcase
  end

  // Load extract: pick the lane, then extend from its top bit unless unsigned.
  always_comb begin
    byteLane = word[{offset, 3'b000} +: BYTE_WIDTH];
    halfLane = word[{offset[1], 4'b0000} +: HALF_WIDTH];
    byteSign = ~isUnsigned & byteLane[BYTE_WIDTH-1];
    halfSign = ~isUnsigned & halfLane[HALF_WIDTH-1];
    case (size)
      SIZE_BYTE: loadData = {{(WORD_WIDTH-BYTE_WIDTH){byteSign}}, byteLane};
      SIZE_HALF: loadData = {{(WORD_WIDTH-HALF_WIDTH){halfSign}}, halfLane};
      default:   loadData = word;
    endcase
  end

endmodule

// File: rtl/bsram_subword_ctrl.sv
// Sub-word access controller in front of the data BSRAM.
// Loads and word stores complete in the request cycle; byte/half stores read
// the old word, merge the new lane(s) and write it back the following cycle
// while req_ready is held low.
// Optional feature: define SUBWORD_MISALIGN_TRAP_EN to reject misaligned
// half/word requests (no BSRAM access, one-cycle misalign_err pulse) instead
// of silently aligning them.
// reset is asynchronous and active-low.
module bsram_subword_ctrl
  import bsram_subword_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  misalign_err,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData
);

  state_t                state;
  state_t                nextState;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  captureMerge;

  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [1:0]            offset;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [DATA_WIDTH-1:0] loadData;

  assign wordAddr = req_addr[ADDR_WIDTH+1:2];

`ifdef SUBWORD_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                      (isWordSize(req_size) && (req_addr[1:0] != 2'b00));
  assign offset     = req_addr[1:0];
`else
  // Without trapping, misaligned requests are forced onto the natural lane.
  assign misaligned = 1'b0;
  assign offset     = isWordSize(req_size)      ? 2'b00 :
                      (req_size == SIZE_HALF)   ? {req_addr[1], 1'b0} :
                                                  req_addr[1:0];
`endif

  subword_lane_mux u_laneMux (
    .word       (readData),
    .newData    (req_wdata),
    .size       (req_size),
    .offset     (offset),
    .isUnsigned (req_unsigned),
    .mergedWord (mergedWord),
    .loadData   (loadData)
  );

  // State, merged word and write-back address registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state <= nextState;
      if (captureMerge) begin
        merge_q <= mergedWord;
        addr_q  <= wordAddr;
      end
    end
  end

  // Next state and BSRAM port muxing; everything stays quiet while in reset.
  always_comb begin
    nextState    = state;
    captureMerge = 1'b0;
    req_ready    = 1'b0;
    resp_rdata   = '0;
    readEnable   = 1'b0;
    readAddress  = '0;
    writeEnable  = 1'b0;
    writeAddress = '0;
    writeData    = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid && !misaligned) begin
            if (!req_write) begin
              readEnable  = 1'b1;
              readAddress = wordAddr;
              resp_rdata  = loadData;
            end else if (isWordSize(req_size)) begin
              writeEnable  = 1'b1;
              writeAddress = wordAddr;
              writeData    = req_wdata;
            end else begin
              readEnable   = 1'b1;
              readAddress  = wordAddr;
              captureMerge = 1'b1;
              nextState    = WRITE;
            end
          end
        end
        WRITE: begin
          writeEnable  = 1'b1;
          writeAddress = addr_q;
          writeData    = merge_q;
          nextState    = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

`ifdef SUBWORD_MISALIGN_TRAP_EN
  // One-cycle error pulse for a rejected misaligned request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (state == IDLE) && req_valid && misaligned;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_bsram_subword_ctrl.sv
// Self-checking bench for bsram_subword_ctrl: directed vector table, a few
// multi-cycle sequences and randomized traffic against a word-array model.
module tb_bsram_subword_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic        readEnable;
  logic [7:0]  readAddress;
  logic [31:0] readData;
  logic        writeEnable;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;

  bsram_subword_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .readEnable   (readEnable),
    .readAddress  (readAddress),
    .readData     (readData),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BSRAM with same-cycle read; cleared while memInit is high.
  logic [31:0] bram [256];
  logic        memInit;
  int          weCount = 0;
  int          cycleCount = 0;

  assign readData = bram[readAddress];

  always @(posedge clock) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) bram[i] <= 32'h0;
    end else if (writeEnable) begin
      bram[writeAddress] <= writeData;
    end
  end

  always @(posedge clock) begin
    cycleCount <= cycleCount + 1;
    if (writeEnable) weCount <= weCount + 1;
  end

  // Reference model: plain word array plus lane arithmetic.
  logic [31:0] refMem [256];
  logic        prevTrap = 1'b0;
  int          nVectors = 0;
  int          nMiscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] word, input int off,
                                          input logic [1:0] sz, input logic uns);
    int v;
    if (sz == 2'b00) begin
      v = int'((word >> (8 * off)) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
      return 32'(v);
    end else if (sz == 2'b01) begin
      v = int'((word >> (8 * off)) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    return word;
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] sz, input int off);
    logic [31:0] mask;
    mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // One request through the controller, checked against the model.
  task automatic doOp(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [9:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    int   w;
    int   off;
    logic trap;
    logic sub;
    w    = int'(addr[9:2]);
    off  = int'(addr[1:0]);
    trap = 1'b0;
`ifdef SUBWORD_MISALIGN_TRAP_EN
    trap = (sz == 2'b01 && (off % 2) != 0) || (sz[1] && off != 0);
`else
    if (sz == 2'b01) off = off - (off % 2);
    if (sz[1]) off = 0;
`endif
    sub = wr && !sz[1] && !trap;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    check("req_ready", req_ready, 32'd1);
    check("misalign_err", misalign_err, 32'(prevTrap));
    rd = resp_rdata;
    if (trap) begin
      check("trap readEnable", readEnable, 32'd0);
      check("trap writeEnable", writeEnable, 32'd0);
      check("trap resp_rdata", resp_rdata, 32'd0);
    end else if (!wr) begin
      check("load readEnable", readEnable, 32'd1);
      check("load readAddress", readAddress, 32'(w));
      check("load writeEnable", writeEnable, 32'd0);
      check("load resp_rdata", resp_rdata, refLoad(refMem[w], off, sz, uns));
    end else if (sz[1]) begin
      check("wstore writeEnable", writeEnable, 32'd1);
      check("wstore writeAddress", writeAddress, 32'(w));
      check("wstore writeData", writeData, wd);
      refMem[w] = wd;
    end else begin
      check("rmw readEnable", readEnable, 32'd1);
      check("rmw readAddress", readAddress, 32'(w));
      check("rmw writeEnable", writeEnable, 32'd0);
      refMem[w] = refMerge(refMem[w], wd, sz, off);
    end
    prevTrap = trap;
    @(posedge clock);
    if (sub) begin
      @(negedge clock);
      // A load is presented during the write-back; it must not be taken.
      req_write = 1'b0;
      #1;
      check("wb req_ready", req_ready, 32'd0);
      check("wb readEnable", readEnable, 32'd0);
      check("wb resp_rdata", resp_rdata, 32'd0);
      check("wb writeEnable", writeEnable, 32'd1);
      check("wb writeAddress", writeAddress, 32'(w));
      check("wb writeData", writeData, refMem[w]);
      check("wb misalign_err", misalign_err, 32'd0);
      @(posedge clock);
    end
  endtask

  task automatic idleCycle();
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3)); req_addr = 10'($urandom_range(0, 1023));
    #1;
    check("idle req_ready", req_ready, 32'd1);
    check("idle readEnable", readEnable, 32'd0);
    check("idle writeEnable", writeEnable, 32'd0);
    check("idle resp_rdata", resp_rdata, 32'd0);
    check("idle misalign_err", misalign_err, 32'(prevTrap));
    prevTrap = 1'b0;
    @(posedge clock);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          c0;
    int          weSnap;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 10'h040, 32'h11223344, 32'h0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 10'h041, 32'h0,        32'h00000033};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 10'h042, 32'h0,        32'h00001122};
    vecs[3]  = '{1'b1, 2'b10, 1'b0, 10'h040, 32'h80FF0000, 32'h0};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 10'h042, 32'h0,        32'hFFFF80FF};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 10'h042, 32'h0,        32'h000080FF};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 10'h043, 32'h0,        32'hFFFFFF80};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 10'h042, 32'h0,        32'h000000FF};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 10'h040, 32'h11223344, 32'h0};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 10'h042, 32'h000000AB, 32'h0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 10'h040, 32'h0,        32'h11AB3344};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 10'h046, 32'h0000BEEF, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 10'h044, 32'h0,        32'hBEEF0000};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 10'h047, 32'h0,        32'hFFFFFFBE};

    for (int i = 0; i < 256; i++) refMem[i] = 32'h0;

    // Reset with a live word-store request presented: nothing may reach the BSRAM.
    reset = 1'b0; memInit = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 10'h040; req_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst req_ready", req_ready, 32'd0);
    check("rst readEnable", readEnable, 32'd0);
    check("rst writeEnable", writeEnable, 32'd0);
    check("rst readAddress", readAddress, 32'd0);
    check("rst writeAddress", writeAddress, 32'd0);
    check("rst writeData", writeData, 32'd0);
    check("rst misalign_err", misalign_err, 32'd0);
    @(negedge clock);
    reset = 1'b1; memInit = 1'b0; req_valid = 1'b0;
    #1;
    check("post-rst req_ready", req_ready, 32'd1);
    @(posedge clock);

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      doOp(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
    end

    // Four back-to-back byte stores into one word: two cycles each.
    c0 = cycleCount;
    for (int i = 0; i < 4; i++) doOp(1'b1, 2'b00, 1'b0, 10'h040 + 10'(i), 32'(i + 1), rd);
    check("bytes occupancy", 32'(cycleCount - c0), 32'd8);
    doOp(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, rd);
    check("bytes word", rd, 32'h04030201);

    // Reset during write-back drops the pending write.
    doOp(1'b1, 2'b10, 1'b0, 10'h040, 32'h11223344, rd);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 10'h042; req_wdata = 32'hAB;
    #1;
    check("rstwb accept", req_ready, 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; reset = 1'b0;
    #1;
    check("rstwb writeEnable", writeEnable, 32'd0);
    check("rstwb req_ready", req_ready, 32'd0);
    weSnap = weCount;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rstwb idle after release", req_ready, 32'd1);
    check("rstwb no write pulse", 32'(weCount - weSnap), 32'd0);
    prevTrap = 1'b0;
    @(posedge clock);
    doOp(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, rd);
    check("rstwb word unchanged", rd, 32'h11223344);

    // Misaligned word store.
    doOp(1'b1, 2'b10, 1'b0, 10'h041, 32'h12345678, rd);
    idleCycle();
    idleCycle();
    doOp(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, rd);
`ifdef SUBWORD_MISALIGN_TRAP_EN
    check("misalign word kept", rd, 32'h11223344);
`else
    check("misalign word aligned", rd, 32'h12345678);
`endif

    // Randomized traffic over a small window of words.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idleCycle();
      end else begin
        doOp(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 31)), $urandom, rd);
      end
    end
    for (int w = 0; w < 8; w++) doOp(1'b0, 2'b10, 1'b0, 10'(w * 4), 32'h0, rd);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/bsram_subword_ctrl.md
# bsram_subword_ctrl

Sub-word access controller that sits directly upstream of the block RAM in the data-memory path of the 5-stage pipeline. Converts byte/halfword/word load and store requests from the memory stage into full-word BSRAM port operations. Sub-word stores become a two-cycle read-modify-write with pipeline back-pressure. Loads are lane-extracted and sign/zero-extended in the same cycle.

## Interface
- DATA_WIDTH, 32: word width; fixed at 32.
- ADDR_WIDTH, 8: BSRAM word-address width; byte address is ADDR_WIDTH+2 bits.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- req_valid  in  1  memory-stage request present.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  loads: zero-extend instead of sign-extend.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_ready  out  1  request accepted this cycle.
- resp_rdata  out  32  extended load data, valid when a load is accepted.
- misalign_err  out  1  registered one-cycle pulse on a misaligned request.
- readEnable, readAddress[ADDR_WIDTH], readData[32] (in)  BSRAM read port.
- writeEnable, writeAddress[ADDR_WIDTH], writeData[32]  BSRAM write port.

## Operation
- FSM states: IDLE, WRITE.
- IDLE, load: readEnable=1, readAddress=req_addr[top:2]. resp_rdata = selected lane of readData, extended. req_ready=1.
- IDLE, word store: writeEnable=1 with req_wdata at the word address. req_ready=1. Stays IDLE.
- IDLE, byte/half store: readEnable=1 on the word address. Register the merged word (old readData with new lane(s) from req_wdata) into merge_q, and the word address into addr_q. req_ready=1. Go to WRITE.
- WRITE: writeEnable=1, writeAddress=addr_q, writeData=merge_q. req_ready=0. Read port idle. Return to IDLE.
- Lane select: byte lane = addr[1:0]; half lane = addr[1]. Byte n occupies bits 8n+7:8n (little-endian).
- Extension: byte sign bit is bit 7 of the lane; half sign bit is bit 15. With req_unsigned=1, upper bits are 0.
- req_valid=0: both BSRAM enables 0, resp_rdata=0.

## Timing
- Reset values: state=IDLE, merge_q=0, addr_q=0, misalign_err=0. While reset is asserted: req_ready=0, and all BSRAM enables/addresses/data = 0.
- Load latency: 0 cycles, combinational through the BSRAM same-cycle read.
- Word store: 1 cycle. Sub-word store: 2 cycles; a new request is accepted no earlier than the cycle after WRITE.
- Back-to-back sub-word stores to the same word are correct because WRITE completes before the next read.
- Reset asserted in WRITE: the pending write is dropped and no writeEnable is issued.
- req_ready is combinational from the state only, never from req_valid.

## Configuration
- SUBWORD_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]≠0, performs no BSRAM access.
  - req_ready=1 and resp_rdata=0 for that request.
  - misalign_err pulses high for one cycle on the next edge.
- SUBWORD_MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment: half clears bit 0, word clears bits 1:0. The access then proceeds normally.
  - misalign_err is tied to 0.

## Structure
- Package bsram_subword_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
  - FSM state typedef (IDLE, WRITE).
  - Lane-width constants.
- One combinational sub-module, subword_lane_mux, provides:
  - store-side lane merge (old word, new data, size, offset → merged word);
  - load-side extract/extend (word, size, offset, unsigned → result).
- The top module holds the FSM, registers and port muxing.

## Test plan
- Word 0x10 preloaded 0x11223344. Load byte at addr 0x41, signed → resp_rdata=0x00000033. Load half at 0x42, signed → 0x00001122.
- Word 0x10 = 0x80FF0000. Load half at 0x42, signed → 0xFFFF80FF. Same load with req_unsigned=1 → 0x000080FF.
- Word 0x10 = 0x11223344. Store byte 0xAB at 0x42 → req_ready low for exactly one cycle; next cycle writeData=0x11AB3344 to address 0x10. A subsequent load word returns 0x11AB3344.
- Back-to-back byte stores 0x01@0x40, 0x02@0x41, 0x03@0x42, 0x04@0x43 → word reads 0x04030201, with 8 cycles total occupancy.
- Reset pulsed low during WRITE of a byte store → no writeEnable pulse; word is unchanged; state=IDLE after release.
- With SUBWORD_MISALIGN_TRAP_EN defined, store word at 0x41 → no writeEnable; misalign_err=1 for one cycle. Without the macro → 0x41 aligns to 0x40 and the write goes to word 0x10.
